// File: rtl/fd_reconstructor_pkg.sv
// Shared constants and FSM state type for the divider reconstruction path.
package fd_reconstructor_pkg;

  localparam int unsigned FDR_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } fdr_state_t;

endpackage

// File: rtl/fd_reconstructor_if.sv
// Start/busy/done handshake and operand/result bus of the reconstructor.
interface fd_reconstructor_if
  import fd_reconstructor_pkg::*;
#(
  parameter int unsigned WIDTH = FDR_WIDTH
);

  logic             start_in;
  logic [WIDTH-1:0] quotient_in;
  logic [WIDTH-1:0] divisor_in;
  logic [WIDTH-1:0] remainder_in;
  logic             dbz_in;
  logic [WIDTH-1:0] dividend_out;
  logic             overflow_out;
  logic             rem_err_out;
  logic             dbz_out;
  logic             busy_out;
  logic             done_out;

  modport master (
    output start_in, quotient_in, divisor_in, remainder_in, dbz_in,
    input  dividend_out, overflow_out, rem_err_out, dbz_out, busy_out, done_out
  );

  modport slave (
    input  start_in, quotient_in, divisor_in, remainder_in, dbz_in,
    output dividend_out, overflow_out, rem_err_out, dbz_out, busy_out, done_out
  );

endinterface

// File: rtl/fd_reconstructor_shift_add_step.sv
// One shift-add multiplier iteration: conditional add, then shift both operands.
module fd_shift_add_step
  import fd_reconstructor_pkg::*;
#(
  parameter int unsigned WIDTH = FDR_WIDTH
) (
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [2*WIDTH-1:0] i_mcand,
  input  logic [WIDTH-1:0]   i_mplier,
  output logic [2*WIDTH-1:0] o_acc,
  output logic [2*WIDTH-1:0] o_mcand,
  output logic [WIDTH-1:0]   o_mplier
);

  always_comb begin
    o_acc    = i_mplier[0] ? (i_acc + i_mcand) : i_acc;
    o_mcand  = i_mcand << 1;
    o_mplier = i_mplier >> 1;
  end

endmodule

// File: rtl/fd_reconstructor.sv
// Rebuilds dividend = quotient*divisor + remainder from a divider result and
// flags overflow and out-of-range remainders.
module fd_reconstructor
  import fd_reconstructor_pkg::*;
#(
  parameter int unsigned WIDTH = FDR_WIDTH
) (
  input  logic                clock,
  input  logic                reset,
  fd_reconstructor_if.slave   bus
);

  localparam int unsigned      CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);

  fdr_state_t          r_state;
  logic [2*WIDTH-1:0]  r_acc;
  logic [2*WIDTH-1:0]  r_mcand;
  logic [WIDTH-1:0]    r_mplier;
  logic [CW-1:0]       r_cnt;
  logic                r_rem_err_q;
  logic                r_dbz_q;
  logic [WIDTH-1:0]    r_dividend;
  logic                r_overflow;
  logic                r_rem_err;
  logic                r_dbz;

  logic [2*WIDTH-1:0]  w_acc_nxt;
  logic [2*WIDTH-1:0]  w_mcand_nxt;
  logic [WIDTH-1:0]    w_mplier_nxt;
  logic                w_accept;

  fd_shift_add_step #(.WIDTH(WIDTH)) u_step (
    .i_acc    (r_acc),
    .i_mcand  (r_mcand),
    .i_mplier (r_mplier),
    .o_acc    (w_acc_nxt),
    .o_mcand  (w_mcand_nxt),
    .o_mplier (w_mplier_nxt)
  );

  assign w_accept = bus.start_in && ((r_state == IDLE) || (r_state == DONE));

  // A dbz request spends one non-busy cycle in CALC so its done pulse lands
  // two clocks after accept without running the multiplier.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_cnt       <= '0;
      r_rem_err_q <= 1'b0;
      r_dbz_q     <= 1'b0;
      r_dividend  <= '0;
      r_overflow  <= 1'b0;
      r_rem_err   <= 1'b0;
      r_dbz       <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_accept) begin
            r_acc       <= {{WIDTH{1'b0}}, bus.remainder_in};
            r_mcand     <= {{WIDTH{1'b0}}, bus.divisor_in};
            r_mplier    <= bus.quotient_in;
            r_cnt       <= '0;
            r_rem_err_q <= !bus.dbz_in && (bus.remainder_in >= bus.divisor_in);
            r_dbz_q     <= bus.dbz_in;
            r_state     <= CALC;
          end else begin
            r_state     <= IDLE;
          end
        end
        CALC: begin
          if (r_dbz_q) begin
            r_dividend <= '0;
            r_overflow <= 1'b0;
            r_rem_err  <= 1'b0;
            r_dbz      <= 1'b1;
            r_state    <= DONE;
          end else begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= w_mcand_nxt;
            r_mplier <= w_mplier_nxt;
            r_cnt    <= r_cnt + 1'b1;
            if (r_cnt == LAST) begin
              r_dividend <= w_acc_nxt[WIDTH-1:0];
              r_overflow <= |w_acc_nxt[2*WIDTH-1:WIDTH];
              r_rem_err  <= r_rem_err_q;
              r_dbz      <= 1'b0;
              r_state    <= DONE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.dividend_out = r_dividend;
  assign bus.overflow_out = r_overflow;
  assign bus.rem_err_out  = r_rem_err;
  assign bus.dbz_out      = r_dbz;
  assign bus.busy_out     = (r_state == CALC) && !r_dbz_q;
  assign bus.done_out     = (r_state == DONE);

endmodule

// File: tb/tb_fd_reconstructor.sv
// Directed scoreboard bench for fd_reconstructor (WIDTH=8, 20-unit clock).
module tb_fd_reconstructor;
  import fd_reconstructor_pkg::*;

  localparam int unsigned W = 8;

  typedef struct packed {
    logic [W-1:0] dividend;
    logic         ovf;
    logic         rem_err;
    logic         dbz;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  fd_reconstructor_if #(.WIDTH(W)) bus ();
  fd_reconstructor #(.WIDTH(W)) dut (.clock(clk), .reset(rst), .bus(bus));

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   done_pulses = 0;
  int   p0;

  always @(negedge clk) if (bus.done_out === 1'b1) done_pulses++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [W-1:0] q, input logic [W-1:0] d,
                       input logic [W-1:0] r, input logic z, input logic s);
    bus.quotient_in  = q;
    bus.divisor_in   = d;
    bus.remainder_in = r;
    bus.dbz_in       = z;
    bus.start_in     = s;
  endtask

  task automatic push_exp(input logic [W-1:0] q, input logic [W-1:0] d,
                          input logic [W-1:0] r, input logic z);
    exp_t        e;
    int unsigned p;
    p = int'(q) * int'(d) + int'(r);
    if (z) begin
      e = '{dividend: '0, ovf: 1'b0, rem_err: 1'b0, dbz: 1'b1};
    end else begin
      e.dividend = p[W-1:0];
      e.ovf      = (p >= 256);
      e.rem_err  = (r >= d);
      e.dbz      = 1'b0;
    end
    sb.push_back(e);
  endtask

  task automatic start_op(input logic [W-1:0] q, input logic [W-1:0] d,
                          input logic [W-1:0] r, input logic z);
    drive(q, d, r, z, 1'b1);
    push_exp(q, d, r, z);
    tick();
    bus.start_in = 1'b0;
  endtask

  // Waits (bounded) for done_out, then checks latency, busy cycles and results.
  task automatic wait_done(input string tag, input int lat0, input int exp_lat, input int exp_busy);
    int   lat;
    int   bc;
    exp_t e;
    lat = lat0;
    bc  = 0;
    while (bus.done_out !== 1'b1 && lat < 40) begin
      if (bus.busy_out === 1'b1) bc++;
      tick();
      lat++;
    end
    check({tag, "_done"}, 32'(bus.done_out), 32'd1);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    if (exp_busy >= 0) check({tag, "_busy"}, 32'(bc), 32'(exp_busy));
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_dividend"}, 32'(bus.dividend_out), 32'(e.dividend));
      check({tag, "_ovf"}, 32'(bus.overflow_out), 32'(e.ovf));
      check({tag, "_rem_err"}, 32'(bus.rem_err_out), 32'(e.rem_err));
      check({tag, "_dbz"}, 32'(bus.dbz_out), 32'(e.dbz));
    end
  endtask

  task automatic check_idle(input string tag);
    tick();
    check({tag, "_done_low"}, 32'(bus.done_out), 32'd0);
    check({tag, "_busy_low"}, 32'(bus.busy_out), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_dividend"}, 32'(bus.dividend_out), 32'd0);
    check({tag, "_ovf"}, 32'(bus.overflow_out), 32'd0);
    check({tag, "_rem_err"}, 32'(bus.rem_err_out), 32'd0);
    check({tag, "_dbz"}, 32'(bus.dbz_out), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy_out), 32'd0);
    check({tag, "_done"}, 32'(bus.done_out), 32'd0);
  endtask

  initial begin
    drive('0, '0, '0, 1'b0, 1'b0);
    #5;
    check_zero("reset");
    tick();
    tick();
    rst = 1'b0;
    tick();

    start_op(8'd13, 8'd7, 8'd3, 1'b0);
    wait_done("basic", 1, 9, 8);
    check_idle("basic");
    check("basic_hold", 32'(bus.dividend_out), 32'd94);

    start_op(8'd255, 8'd255, 8'd254, 1'b0);
    wait_done("max", 1, 9, 8);
    check_idle("max");

    start_op(8'd13, 8'd0, 8'd3, 1'b1);
    wait_done("dbz", 1, 2, 0);
    check_idle("dbz");

    start_op(8'd0, 8'd7, 8'd5, 1'b0);
    wait_done("q0", 1, 9, 8);
    check_idle("q0");

    start_op(8'd9, 8'd0, 8'd3, 1'b0);
    wait_done("d0", 1, 9, 8);
    check_idle("d0");

    start_op(8'd2, 8'd5, 8'd5, 1'b0);
    wait_done("b2b_a", 1, 9, 8);
    drive(8'd1, 8'd1, 8'd0, 1'b0, 1'b1);
    push_exp(8'd1, 8'd1, 8'd0, 1'b0);
    tick();
    bus.start_in = 1'b0;
    wait_done("b2b_b", 1, 9, 8);
    check_idle("b2b_b");

    p0 = done_pulses;
    start_op(8'd100, 8'd3, 8'd2, 1'b0);
    tick();
    tick();
    drive(8'd9, 8'd9, 8'd1, 1'b0, 1'b1);
    tick();
    bus.start_in = 1'b0;
    wait_done("ign", 4, 9, -1);
    repeat (4) tick();
    check("ign_pulses", 32'(done_pulses - p0), 32'd1);
    check("ign_sb", 32'(sb.size()), 32'd0);

    p0 = done_pulses;
    drive(8'd13, 8'd7, 8'd3, 1'b0, 1'b1);
    tick();
    bus.start_in = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    #1;
    check_zero("midrst");
    tick();
    rst = 1'b0;
    repeat (12) tick();
    check("midrst_pulses", 32'(done_pulses - p0), 32'd0);

    start_op(8'd13, 8'd7, 8'd3, 1'b0);
    wait_done("postrst", 1, 9, 8);
    check_idle("postrst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
